parity_stream_gen_chk: RTL and testbench

//  Parametrised, pipelined parity generator/checker for a valid/ready word stream.
//  Per beat: generate mode appends the parity bit; check mode verifies the received

---
 rtl/parity_stream_gen_chk.sv | 128 ++++++++++++
 tb/tb_parity_stream_gen_chk.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/parity_stream_gen_chk.sv
// Parity generator/checker on a valid/ready stream, backed by a 2-entry skid buffer.
// Latency: a beat accepted at edge k is presented on out_* from edge k onward.
// Backpressure: the buffer holds two beats; in_ready is registered and drops only when the buffer goes FULL.
module parity_stream_gen_chk #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W:0]   in_data,
  input  logic              odd_mode,
  input  logic              chk_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   out_data,
  output logic              out_err,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef struct packed {
    logic            err;
    logic [DATA_W:0] dat;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state, state_nxt;
  entry_t head, tail, new_ent;
  logic   push, pop, par;
  logic   head_ld_new, head_ld_tail, tail_ld;

  assign push      = in_valid & in_ready;
  assign out_valid = (state != EMPTY);
  assign pop       = out_valid & out_ready;
  assign out_data  = head.dat;
  assign out_err   = head.err;

  // Parity result for the incoming beat, computed once at acceptance.
  always_comb begin
    new_ent = '0;
    par     = (^in_data[DATA_W-1:0]) ^ odd_mode;
    if (chk_mode) begin
      new_ent.dat = in_data;
      new_ent.err = in_data[DATA_W] ^ par;
    end else begin
      new_ent.dat = {par, in_data[DATA_W-1:0]};
      new_ent.err = 1'b0;
    end
  end

  // Buffer occupancy next-state and entry load controls.
  always_comb begin
    state_nxt    = state;
    head_ld_new  = 1'b0;
    head_ld_tail = 1'b0;
    tail_ld      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt   = ONE;
          head_ld_new = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_ld_new = 1'b1;
        end else if (push) begin
          state_nxt = FULL;
          tail_ld   = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_nxt    = ONE;
          head_ld_tail = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // State register; in_ready is registered and low only while the buffer is FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
    end
  end

  // Entry storage: head is the oldest beat, tail the second one when FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (head_ld_new) begin
        head <= new_ent;
      end else if (head_ld_tail) begin
        head <= tail;
      end
      if (tail_ld) begin
        tail <= new_ent;
      end
    end
  end

  // Saturating error counter; clear wins over a simultaneous error push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (push && new_ent.err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_parity_stream_gen_chk.sv
module tb_parity_stream_gen_chk;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       odd_mode;
  logic       chk_mode;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_err;
  logic       clr_cnt;
  logic [1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {err, data}, error count, expected in_ready.
  logic [4:0] q[$];
  int         exp_cnt;
  bit         exp_rdy;

  logic [3:0] gen_odd_tab [8];

  parity_stream_gen_chk #(.DATA_W(3), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .odd_mode(odd_mode), .chk_mode(chk_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err),
    .clr_cnt(clr_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [3:0] d, input bit odd, input bit chk,
                       input bit ordy, input bit clr);
    in_valid  = v;
    in_data   = d;
    odd_mode  = odd;
    chk_mode  = chk;
    out_ready = ordy;
    clr_cnt   = clr;
  endtask

  // One clock: check outputs against the model at negedge, then advance the model at posedge.
  task automatic cyc();
    bit         push, pop, p, err;
    int         ones;
    logic [3:0] dat;
    @(negedge clk);
    check("in_ready", 8'(in_ready), 8'(exp_rdy));
    check("out_valid", 8'(out_valid), 8'(q.size() > 0));
    if (q.size() > 0) begin
      check("out_data", 8'(out_data), 8'(q[0][3:0]));
      check("out_err", 8'(out_err), 8'(q[0][4]));
    end
    check("err_cnt", 8'(err_cnt), 8'(exp_cnt));
    push = in_valid && exp_rdy && rst_n;
    pop  = (q.size() > 0) && out_ready;
    ones = $countones(in_data[2:0]);
    if (chk_mode) begin
      dat = in_data;
      err = (($countones(in_data) % 2) == 1) != odd_mode;
    end else begin
      p   = odd_mode ^ (ones % 2 == 1);
      dat = {p, in_data[2:0]};
      err = 1'b0;
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      q.delete();
      exp_cnt = 0;
      exp_rdy = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back({err, dat});
      if (clr_cnt) exp_cnt = 0;
      else if (push && err && exp_cnt < 3) exp_cnt++;
      exp_rdy = (q.size() < 2);
    end
  endtask

  initial begin
    gen_odd_tab = '{4'h8, 4'h1, 4'h2, 4'hB, 4'h4, 4'hD, 4'hE, 4'h7};
    rst_n   = 1'b0;
    exp_cnt = 0;
    exp_rdy = 1'b0;
    drive(0, 4'h0, 0, 0, 0, 0);
    #3;
    check("rst_out_valid", 8'(out_valid), 8'h0);
    check("rst_in_ready", 8'(in_ready), 8'h0);
    check("rst_out_data", 8'(out_data), 8'h0);
    check("rst_err_cnt", 8'(err_cnt), 8'h0);
    drive(1, 4'h5, 1, 0, 1, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    check("rdy_after_rst", 8'(in_ready), 8'h1);

    // Generate, odd: full payload sweep at one beat per clock.
    for (int d = 0; d < 8; d++) begin
      drive(1, 4'(d), 1, 0, 1, 0);
      cyc();
      check("gen_odd_tab", 8'(out_data), 8'(gen_odd_tab[d]));
      check("gen_odd_err", 8'(out_err), 8'h0);
    end

    // Generate, even.
    drive(1, 4'b0011, 0, 0, 1, 0);
    cyc();
    check("gen_even_011", 8'(out_data), 8'h3);
    drive(1, 4'b0001, 0, 0, 1, 0);
    cyc();
    check("gen_even_001", 8'(out_data), 8'h9);
    check("gen_even_cnt", 8'(err_cnt), 8'h0);

    // Check mode.
    drive(1, 4'b0011, 1, 1, 1, 0);
    cyc();
    check("chk_odd_bad_err", 8'(out_err), 8'h1);
    check("chk_odd_bad_dat", 8'(out_data), 8'h3);
    drive(1, 4'b1011, 1, 1, 1, 0);
    cyc();
    check("chk_odd_bad_cnt", 8'(err_cnt), 8'h1);
    check("chk_odd_ok_err", 8'(out_err), 8'h0);
    drive(1, 4'b0011, 0, 1, 1, 0);
    cyc();
    check("chk_even_ok_err", 8'(out_err), 8'h0);

    // Backpressure: drain, then stall with continuous in_valid.
    drive(0, 4'h0, 0, 0, 1, 0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 0, 0);
      cyc();
    end
    check("bp_in_ready", 8'(in_ready), 8'h0);
    check("bp_depth", 8'(q.size()), 8'h2);
    for (int i = 0; i < 6; i++) begin
      drive(1, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1, 0);
      cyc();
    end

    // Saturation with CNT_W=2, then clear racing an error beat.
    drive(0, 4'h0, 0, 0, 1, 1);
    cyc();
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'b0011, 1, 1, 1, 0);
      cyc();
    end
    check("sat_cnt", 8'(err_cnt), 8'h3);
    drive(1, 4'b0011, 1, 1, 1, 1);
    cyc();
    check("clr_prio_cnt", 8'(err_cnt), 8'h0);

    // Reset while FULL, asserted between edges.
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'b0111, 0, 1, 0, 0);
      cyc();
    end
    check("pre_rst_full", 8'(in_ready), 8'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 8'(out_valid), 8'h0);
    check("mid_rst_err_cnt", 8'(err_cnt), 8'h0);
    check("mid_rst_in_ready", 8'(in_ready), 8'h0);
    check("mid_rst_out_data", 8'(out_data), 8'h0);
    q.delete();
    exp_cnt = 0;
    exp_rdy = 1'b0;
    drive(1, 4'h6, 1, 0, 1, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    check("post_rst_rdy", 8'(in_ready), 8'h1);

    // Randomized mixed traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
